// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control unit: operation codes,
// ALUOp and funct7 encodings, and the M-extension sequencing FSM states.
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    localparam logic [1:0] ALUOP_LS = 2'b00;
    localparam logic [1:0] ALUOP_BR = 2'b01;
    localparam logic [1:0] ALUOP_I  = 2'b10;
    localparam logic [1:0] ALUOP_R  = 2'b11;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of ALUOp/funct7/funct3 into the ALU/M operation code,
// plus the M-extension and divide/remainder qualifiers used by the sequencer.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int NB_OP    = 5,
    parameter int ENABLE_M = 1
) (
    input  logic [1:0]       i_alu_op,
    input  logic [6:0]       i_funct7,
    input  logic [2:0]       i_funct3,
    output logic [NB_OP-1:0] o_alu_op,
    output logic             o_is_m,
    output logic             o_is_div
);

    logic [4:0] code;
    logic       is_m;

    // Decode table; every undefined combination falls back to ADD.
    always_comb begin
        code = ALU_ADD;
        is_m = 1'b0;
        case (i_alu_op)
            ALUOP_BR: begin
                case (i_funct3)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        code = ALU_ADD;
                endcase
            end
            ALUOP_I: begin
                case (i_funct3)
                    3'b000: code = ALU_ADD;
                    3'b001: code = ALU_SLL;
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b101: begin
                        if (i_funct7 == FUNCT7_BASE)     code = ALU_SRL;
                        else if (i_funct7 == FUNCT7_ALT) code = ALU_SRA;
                        else                             code = ALU_ADD;
                    end
                    3'b110: code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            ALUOP_R: begin
                if (i_funct7 == FUNCT7_BASE) begin
                    case (i_funct3)
                        3'b000: code = ALU_ADD;
                        3'b001: code = ALU_SLL;
                        3'b010: code = ALU_SLT;
                        3'b011: code = ALU_SLTU;
                        3'b100: code = ALU_XOR;
                        3'b101: code = ALU_SRL;
                        3'b110: code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end else if (i_funct7 == FUNCT7_ALT) begin
                    case (i_funct3)
                        3'b000:  code = ALU_SUB;
                        3'b101:  code = ALU_SRA;
                        default: code = ALU_ADD;
                    endcase
                end else if ((i_funct7 == FUNCT7_MEXT) && (ENABLE_M != 0)) begin
                    // MUL..REMU are laid out contiguously in funct3 order.
                    code = ALU_MUL + {2'b00, i_funct3};
                    is_m = 1'b1;
                end
            end
            default: code = ALU_ADD;
        endcase
    end

    assign o_alu_op = NB_OP'(code);
    assign o_is_m   = is_m;
    assign o_is_div = is_m & i_funct3[2];

endmodule

// File: rtl/alu_md_ctrl_unit.sv
// EX-stage ALU control with RV32M sequencing. Base ops decode with zero
// latency; M ops start the external M unit, stall the pipeline for the unit's
// latency and then flag the result valid for one cycle.
// Handshake: o_md_start and o_md_kill are single-cycle pulses; o_md_valid is
// high for exactly the one cycle in which the M instruction retires, and the
// pipeline is stalled from the start cycle until the cycle before that.
module alu_md_ctrl_unit
    import alu_pkg::*;
#(
    parameter int NB_OP    = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_flush,
    input  logic [1:0]       i_alu_op,
    input  logic [6:0]       i_funct7,
    input  logic [2:0]       i_funct3,
    input  logic             i_rs2_zero,
    output logic [NB_OP-1:0] o_alu_op,
    output logic             o_md_start,
    output logic             o_md_kill,
    output logic             o_md_valid,
    output logic             o_stall
);

    localparam int CNT_W = $clog2(lat_max(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic             is_m;
    logic             is_div;
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_start, md_kill, md_valid, stall;

    alu_op_decoder #(
        .NB_OP    (NB_OP),
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .i_alu_op (i_alu_op),
        .i_funct7 (i_funct7),
        .i_funct3 (i_funct3),
        .o_alu_op (o_alu_op),
        .o_is_m   (is_m),
        .o_is_div (is_div)
    );

    // State and latency counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        md_kill  = 1'b0;
        md_valid = 1'b0;
        stall    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (i_valid && is_m && !i_flush) begin
                    md_start = 1'b1;
                    stall    = 1'b1;
                    // Divide by zero needs no M-unit latency: result is fixed.
                    if (is_div && i_rs2_zero) begin
                        state_d = MD_DONE;
                    end else begin
                        cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                if (i_flush) begin
                    // Killed instruction: abort the unit and release the
                    // pipeline so the redirect can proceed.
                    md_kill = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt_q == '0) state_d = MD_DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            MD_DONE: begin
                md_valid = !i_flush;
                state_d  = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    assign o_md_start = md_start & i_rst_n;
    assign o_md_kill  = md_kill  & i_rst_n;
    assign o_md_valid = md_valid & i_rst_n;
    assign o_stall    = stall    & i_rst_n;

endmodule

// File: tb/tb_alu_md_ctrl_unit.sv
// Directed bench for alu_md_ctrl_unit: decode table, M-op latency sequencing,
// divide by zero, flush, back-to-back ops, mid-op reset and ENABLE_M=0.
module tb_alu_md_ctrl_unit;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       i_flush;
    logic [1:0] i_alu_op;
    logic [6:0] i_funct7;
    logic [2:0] i_funct3;
    logic       i_rs2_zero;

    logic [4:0] o_alu_op;
    logic       o_md_start, o_md_kill, o_md_valid, o_stall;
    logic [4:0] n_alu_op;
    logic       n_md_start, n_md_kill, n_md_valid, n_stall;

    int n_checks = 0;
    int n_fail   = 0;

    alu_md_ctrl_unit #(.NB_OP(5), .ENABLE_M(1), .MUL_LAT(2), .DIV_LAT(32)) dut (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .i_valid (i_valid), .i_flush (i_flush),
        .i_alu_op (i_alu_op), .i_funct7 (i_funct7), .i_funct3 (i_funct3),
        .i_rs2_zero (i_rs2_zero), .o_alu_op (o_alu_op), .o_md_start (o_md_start),
        .o_md_kill (o_md_kill), .o_md_valid (o_md_valid), .o_stall (o_stall)
    );

    alu_md_ctrl_unit #(.NB_OP(5), .ENABLE_M(0), .MUL_LAT(2), .DIV_LAT(32)) dut_nom (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .i_valid (i_valid), .i_flush (i_flush),
        .i_alu_op (i_alu_op), .i_funct7 (i_funct7), .i_funct3 (i_funct3),
        .i_rs2_zero (i_rs2_zero), .o_alu_op (n_alu_op), .o_md_start (n_md_start),
        .o_md_kill (n_md_kill), .o_md_valid (n_md_valid), .o_stall (n_stall)
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // {alu_op, funct7, funct3, expected code}
    logic [16:0] dec_vec [$] = '{
        {2'b00, 7'h00, 3'd0, 5'd0},  {2'b00, 7'h01, 3'd7, 5'd0},
        {2'b01, 7'h00, 3'd0, 5'd1},  {2'b01, 7'h00, 3'd1, 5'd1},
        {2'b01, 7'h00, 3'd4, 5'd3},  {2'b01, 7'h00, 3'd5, 5'd3},
        {2'b01, 7'h00, 3'd6, 5'd4},  {2'b01, 7'h00, 3'd7, 5'd4},
        {2'b01, 7'h00, 3'd2, 5'd0},  {2'b01, 7'h00, 3'd3, 5'd0},
        {2'b10, 7'h00, 3'd0, 5'd0},  {2'b10, 7'h00, 3'd1, 5'd2},
        {2'b10, 7'h00, 3'd2, 5'd3},  {2'b10, 7'h00, 3'd3, 5'd4},
        {2'b10, 7'h00, 3'd4, 5'd5},  {2'b10, 7'h00, 3'd5, 5'd6},
        {2'b10, 7'h20, 3'd5, 5'd7},  {2'b10, 7'h01, 3'd5, 5'd0},
        {2'b10, 7'h00, 3'd6, 5'd8},  {2'b10, 7'h00, 3'd7, 5'd9},
        {2'b10, 7'h20, 3'd1, 5'd2},
        {2'b11, 7'h00, 3'd0, 5'd0},  {2'b11, 7'h00, 3'd1, 5'd2},
        {2'b11, 7'h00, 3'd2, 5'd3},  {2'b11, 7'h00, 3'd3, 5'd4},
        {2'b11, 7'h00, 3'd4, 5'd5},  {2'b11, 7'h00, 3'd5, 5'd6},
        {2'b11, 7'h00, 3'd6, 5'd8},  {2'b11, 7'h00, 3'd7, 5'd9},
        {2'b11, 7'h20, 3'd0, 5'd1},  {2'b11, 7'h20, 3'd5, 5'd7},
        {2'b11, 7'h20, 3'd1, 5'd0},  {2'b11, 7'h20, 3'd2, 5'd0},
        {2'b11, 7'h20, 3'd3, 5'd0},  {2'b11, 7'h20, 3'd4, 5'd0},
        {2'b11, 7'h20, 3'd6, 5'd0},  {2'b11, 7'h20, 3'd7, 5'd0},
        {2'b11, 7'h01, 3'd0, 5'd10}, {2'b11, 7'h01, 3'd1, 5'd11},
        {2'b11, 7'h01, 3'd2, 5'd12}, {2'b11, 7'h01, 3'd3, 5'd13},
        {2'b11, 7'h01, 3'd4, 5'd14}, {2'b11, 7'h01, 3'd5, 5'd15},
        {2'b11, 7'h01, 3'd6, 5'd16}, {2'b11, 7'h01, 3'd7, 5'd17}
    };

    // Driver tasks
    task automatic idle_inputs();
        i_valid = 1'b0; i_flush = 1'b0; i_alu_op = 2'b00;
        i_funct7 = 7'h00; i_funct3 = 3'd0; i_rs2_zero = 1'b0;
    endtask

    task automatic set_m(input logic [2:0] f3, input logic rs2z);
        i_valid = 1'b1; i_flush = 1'b0; i_alu_op = 2'b11;
        i_funct7 = 7'b0000001; i_funct3 = f3; i_rs2_zero = rs2z;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_m(3'd0, 1'b0);
        repeat (2) @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_md_start, o_md_kill, o_md_valid, o_stall} !== 4'b0000) begin
            $display("FAIL reset_outputs got=%b exp=0000", {o_md_start, o_md_kill, o_md_valid, o_stall});
            n_fail++;
        end
        n_checks++;
        if (o_alu_op !== 5'd10) begin
            $display("FAIL reset_alu_op got=%0d exp=10", o_alu_op);
            n_fail++;
        end
        @(negedge i_clk);
        idle_inputs();
        i_rst_n = 1'b1;
        #1;
        n_checks++;
        if ({o_md_start, o_md_valid, o_stall} !== 3'b000) begin
            $display("FAIL post_reset_idle got=%b exp=000", {o_md_start, o_md_valid, o_stall});
            n_fail++;
        end
    endtask

    task automatic test_decode();
        logic [1:0] aop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] exp;
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int i = 0; i < dec_vec.size(); i++) begin
            {aop, f7, f3, exp} = dec_vec[i];
            i_alu_op = aop; i_funct7 = f7; i_funct3 = f3;
            #1;
            n_checks++;
            if (o_alu_op !== exp) begin
                $display("FAIL decode aop=%b f7=%b f3=%b got=%0d exp=%0d", aop, f7, f3, o_alu_op, exp);
                n_fail++;
            end
        end
        // Undefined R-type funct7 values always decode as ADD.
        i_alu_op = 2'b11;
        for (int f = 0; f < 128; f++) begin
            if (f != 0 && f != 'h20 && f != 1) begin
                for (int g = 0; g < 8; g++) begin
                    i_funct7 = 7'(f); i_funct3 = 3'(g);
                    #1;
                    n_checks++;
                    if (o_alu_op !== 5'd0) begin
                        $display("FAIL decode_undef f7=%b f3=%b got=%0d exp=0", i_funct7, i_funct3, o_alu_op);
                        n_fail++;
                    end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_base_ops();
        @(negedge i_clk);
        i_valid = 1'b1; i_alu_op = 2'b11; i_funct7 = 7'h20; i_funct3 = 3'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({o_md_start, o_stall, o_md_valid} !== 3'b000 || o_alu_op !== 5'd1) begin
                $display("FAIL base_op cyc=%0d got=%b/%0d exp=000/1", k, {o_md_start, o_stall, o_md_valid}, o_alu_op);
                n_fail++;
            end
            @(negedge i_clk);
        end
        idle_inputs();
    endtask

    task automatic test_mul();
        @(negedge i_clk);
        set_m(3'd0, 1'b0);
        #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b110 || o_alu_op !== 5'd10) begin
            $display("FAIL mul_start got=%b/%0d exp=110/10", {o_md_start, o_stall, o_md_valid}, o_alu_op);
            n_fail++;
        end
        for (int k = 1; k <= 2; k++) begin
            @(negedge i_clk); #1;
            n_checks++;
            if ({o_md_start, o_stall, o_md_valid} !== 3'b010) begin
                $display("FAIL mul_busy t+%0d got=%b exp=010", k, {o_md_start, o_stall, o_md_valid});
                n_fail++;
            end
        end
        @(negedge i_clk); #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b001) begin
            $display("FAIL mul_done got=%b exp=001", {o_md_start, o_stall, o_md_valid});
            n_fail++;
        end
        @(negedge i_clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b000) begin
            $display("FAIL mul_after got=%b exp=000", {o_md_start, o_stall, o_md_valid});
            n_fail++;
        end
    endtask

    task automatic test_div_zero();
        @(negedge i_clk);
        set_m(3'b101, 1'b1);
        #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b110 || o_alu_op !== 5'd15) begin
            $display("FAIL divz_start got=%b/%0d exp=110/15", {o_md_start, o_stall, o_md_valid}, o_alu_op);
            n_fail++;
        end
        @(negedge i_clk); #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b001) begin
            $display("FAIL divz_done got=%b exp=001", {o_md_start, o_stall, o_md_valid});
            n_fail++;
        end
        @(negedge i_clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({o_stall, o_md_valid} !== 2'b00) begin
            $display("FAIL divz_after got=%b exp=00", {o_stall, o_md_valid});
            n_fail++;
        end
    endtask

    task automatic test_div_flush();
        @(negedge i_clk);
        set_m(3'b100, 1'b0);
        #1;
        n_checks++;
        if (o_md_start !== 1'b1) begin
            $display("FAIL divf_start got=%b exp=1", o_md_start);
            n_fail++;
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge i_clk); #1;
            n_checks++;
            if ({o_md_start, o_md_kill, o_stall, o_md_valid} !== 4'b0010) begin
                $display("FAIL divf_busy t+%0d got=%b exp=0010", k, {o_md_start, o_md_kill, o_stall, o_md_valid});
                n_fail++;
            end
        end
        @(negedge i_clk);
        i_flush = 1'b1;
        #1;
        n_checks++;
        if ({o_md_start, o_md_kill, o_md_valid} !== 3'b010) begin
            $display("FAIL divf_kill got=%b exp=010", {o_md_start, o_md_kill, o_md_valid});
            n_fail++;
        end
        @(negedge i_clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({o_md_kill, o_stall, o_md_valid} !== 3'b000) begin
            $display("FAIL divf_idle got=%b exp=000", {o_md_kill, o_stall, o_md_valid});
            n_fail++;
        end
        // Flush in IDLE suppresses the start.
        @(negedge i_clk);
        set_m(3'b100, 1'b0);
        i_flush = 1'b1;
        #1;
        n_checks++;
        if ({o_md_start, o_stall} !== 2'b00) begin
            $display("FAIL idle_flush got=%b exp=00", {o_md_start, o_stall});
            n_fail++;
        end
        @(negedge i_clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({o_stall, o_md_valid} !== 2'b00) begin
            $display("FAIL idle_flush_after got=%b exp=00", {o_stall, o_md_valid});
            n_fail++;
        end
    endtask

    task automatic test_flush_done();
        @(negedge i_clk);
        set_m(3'd3, 1'b0);
        repeat (3) @(negedge i_clk);
        i_flush = 1'b1;
        #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b000) begin
            $display("FAIL done_flush got=%b exp=000", {o_md_start, o_stall, o_md_valid});
            n_fail++;
        end
        @(negedge i_clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({o_stall, o_md_valid} !== 2'b00) begin
            $display("FAIL done_flush_after got=%b exp=00", {o_stall, o_md_valid});
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk);
        set_m(3'b110, 1'b0);
        for (int op = 0; op < 2; op++) begin
            #1;
            n_checks++;
            if ({o_md_start, o_stall, o_md_valid} !== 3'b110 || o_alu_op !== 5'd16) begin
                $display("FAIL b2b_start op=%0d got=%b/%0d exp=110/16", op, {o_md_start, o_stall, o_md_valid}, o_alu_op);
                n_fail++;
            end
            for (int k = 1; k <= 32; k++) begin
                @(negedge i_clk); #1;
                n_checks++;
                if ({o_md_start, o_stall, o_md_valid} !== 3'b010) begin
                    $display("FAIL b2b_busy op=%0d t+%0d got=%b exp=010", op, k, {o_md_start, o_stall, o_md_valid});
                    n_fail++;
                end
            end
            @(negedge i_clk); #1;
            n_checks++;
            if ({o_md_start, o_stall, o_md_valid} !== 3'b001) begin
                $display("FAIL b2b_done op=%0d got=%b exp=001", op, {o_md_start, o_stall, o_md_valid});
                n_fail++;
            end
            @(negedge i_clk);
        end
        idle_inputs();
        #1;
        n_checks++;
        if ({o_md_start, o_stall, o_md_valid} !== 3'b000) begin
            $display("FAIL b2b_after got=%b exp=000", {o_md_start, o_stall, o_md_valid});
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_div();
        @(negedge i_clk);
        set_m(3'b100, 1'b0);
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_md_start, o_md_kill, o_md_valid, o_stall} !== 4'b0000) begin
            $display("FAIL rst_mid got=%b exp=0000", {o_md_start, o_md_kill, o_md_valid, o_stall});
            n_fail++;
        end
        @(negedge i_clk); #1;
        n_checks++;
        if ({o_md_start, o_md_kill, o_md_valid, o_stall} !== 4'b0000) begin
            $display("FAIL rst_hold got=%b exp=0000", {o_md_start, o_md_kill, o_md_valid, o_stall});
            n_fail++;
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_valid = 1'b1; i_alu_op = 2'b11; i_funct7 = 7'h00; i_funct3 = 3'd0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({o_md_start, o_stall, o_md_valid} !== 3'b000 || o_alu_op !== 5'd0) begin
                $display("FAIL rst_add cyc=%0d got=%b/%0d exp=000/0", k, {o_md_start, o_stall, o_md_valid}, o_alu_op);
                n_fail++;
            end
            @(negedge i_clk);
        end
        idle_inputs();
    endtask

    task automatic test_enable_m_off();
        @(negedge i_clk);
        set_m(3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if ({n_md_start, n_md_kill, n_md_valid, n_stall} !== 4'b0000 || n_alu_op !== 5'd0) begin
                $display("FAIL m_off cyc=%0d got=%b/%0d exp=0000/0", k, {n_md_start, n_md_kill, n_md_valid, n_stall}, n_alu_op);
                n_fail++;
            end
            @(negedge i_clk);
        end
        i_funct3 = 3'b101; i_rs2_zero = 1'b1;
        #1;
        n_checks++;
        if ({n_md_start, n_stall} !== 2'b00 || n_alu_op !== 5'd0) begin
            $display("FAIL m_off_div got=%b/%0d exp=00/0", {n_md_start, n_stall}, n_alu_op);
            n_fail++;
        end
        idle_inputs();
        repeat (4) @(negedge i_clk);
    endtask

    // Test sequence and final report.
    initial begin
        i_rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_decode();
        test_base_ops();
        test_mul();
        test_div_zero();
        test_div_flush();
        test_flush_done();
        test_back_to_back();
        test_reset_mid_div();
        test_enable_m_off();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md_ctrl_unit.md
# alu_md_ctrl_unit

Parametrised successor ALU control unit for the EX stage, extended with RV32M multiply/divide sequencing. It decodes ALUOp/funct7/funct3 into a 5-bit ALU operation code, covering all base ALU ops plus MUL…REMU. For M-extension ops it runs a latency FSM that starts the external multi-cycle M unit, stalls the pipeline, and flags when the M result is valid. Sits between the main control unit and the ALU/M-unit in EX; base ops pass through with zero latency.

## Interface
Parameters:
- NB_OP, 5: width of ALU op code
- ENABLE_M, 1: 1 = decode and sequence RV32M; 0 = funct7 0000001 decodes as default ADD, FSM never leaves IDLE
- MUL_LAT, 2: M-unit multiply latency in cycles, ≥1
- DIV_LAT, 32: M-unit divide/remainder latency in cycles, ≥1

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  instruction in EX is valid
- i_flush  in  1  kill EX instruction (branch/exception)
- i_alu_op  in  2  ALUOp: 00 load/store, 01 branch, 10 I-type, 11 R-type
- i_funct7  in  7  instruction funct7
- i_funct3  in  3  instruction funct3
- i_rs2_zero  in  1  divisor operand is zero
- o_alu_op  out  NB_OP  ALU/M operation code (combinational)
- o_md_start  out  1  one-cycle start pulse to M unit
- o_md_kill  out  1  one-cycle abort pulse to M unit
- o_md_valid  out  1  M result valid; selects M unit in writeback mux
- o_stall  out  1  hold IF/ID/EX pipeline registers

## Operation
- Codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- ALUOp 00 → ADD. 01 → funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU, else ADD. 10 → I-type by funct3; 101 uses funct7 0000000 SRL, 0100000 SRA, else ADD. 11 → {funct7,funct3} R-type; funct7 0000001 (ENABLE_M=1) → MUL+funct3; any undefined combination → ADD.
- is_m = ALUOp 11 & funct7 0000001 & ENABLE_M. is_div = is_m & funct3[2].
- FSM states IDLE, BUSY, DONE:
  - IDLE: if i_valid & is_m & !i_flush, assert o_md_start and o_stall (combinational). If is_div & i_rs2_zero, go to DONE. Otherwise load cnt = LAT−1 (DIV_LAT if is_div, else MUL_LAT) and go to BUSY.
  - BUSY: o_stall=1. Decrement cnt. When cnt==0, go to DONE.
  - DONE: o_md_valid=1, o_stall=0. Instruction retires. Go to IDLE unconditionally. No start in DONE even though i_valid/is_m are still high.
- i_flush in BUSY: go to IDLE, pulse o_md_kill, no o_md_valid. i_flush in DONE: go to IDLE, o_md_valid=0. i_flush in IDLE: suppresses start.
- Counter width $clog2(max(MUL_LAT,DIV_LAT)+1). No wrap: it is loaded only in IDLE.

## Timing
- Reset: state IDLE, cnt 0. o_md_start, o_md_kill, o_md_valid, o_stall all 0 while i_rst_n low. o_alu_op stays combinational.
- Reset deassertion mid-operation returns to IDLE. The M unit must be reset by the same reset.
- M op accepted at cycle T: stall from T to T+LAT. DONE and o_md_valid at T+LAT+1. EX occupancy is LAT+2 cycles.
- Divide by zero: start at T, DONE at T+1. The M unit supplies the RISC-V defined result.
- Back-to-back M ops: the second one starts the cycle after DONE.
- Base ops: zero latency, no stall.

## Structure
- alu_pkg: op code localparams (ALU_ADD…ALU_REMU), ALUOp encodings, FUNCT7_BASE/ALT/MEXT constants, FSM state encodings.
- One sub-module, alu_op_decoder: purely combinational decode to o_alu_op, is_m, is_div.
- Top level: FSM, latency counter, handshake outputs.

## Test plan
- Full decode sweep: every ALUOp/funct7/funct3 combination → expected code. Undefined combinations → 0. funct7 0000001 with ENABLE_M=0 → 0, FSM stays IDLE.
- MUL (funct3 000, MUL_LAT=2) at T → o_md_start@T, o_stall T..T+2, o_md_valid@T+3 only.
- DIVU with i_rs2_zero=1 → start@T, stall@T only, o_md_valid@T+1.
- DIV (DIV_LAT=32) with i_flush at T+10 → o_md_kill@T+10, state IDLE@T+11, no o_md_valid.
- Two consecutive REM ops → second o_md_start exactly one cycle after first o_md_valid. No restart during DONE.
- i_rst_n low at T+5 of a DIV → all outputs 0 asynchronously. After release, a new ADD gives no stall.
